// File: rtl/ff_fifo_any_depth_flags.sv
// Single-clock show-ahead FIFO for any depth >= 2. Keeps an occupancy counter
// and decodes programmable almost-full/almost-empty thresholds from it. Also
// has a synchronous flush and sticky overflow/underflow error flags.
module ff_fifo_any_depth_flags #(
  parameter int unsigned width              = 8,
  parameter int unsigned depth              = 6,
  parameter int unsigned almost_full_level  = 4,
  parameter int unsigned almost_empty_level = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = $clog2(depth + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(depth);
  localparam logic [CntW-1:0] AfLevel = CntW'(almost_full_level);
  localparam logic [CntW-1:0] AeLevel = CntW'(almost_empty_level);

`ifndef SYNTHESIS
  if (depth < 2) begin : g_bad_depth
    $error("ff_fifo_any_depth_flags: depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
    $error("ff_fifo_any_depth_flags: almost_full_level must be in 1..depth");
  end
  if (almost_empty_level >= depth) begin : g_bad_ae
    $error("ff_fifo_any_depth_flags: almost_empty_level must be in 0..depth-1");
  end
`endif

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  // Status flags decode only from the registered count.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == FullCnt);
    almost_empty = (count_q <= AeLevel);
    almost_full  = (count_q >= AfLevel);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    read_data    = mem_q[rd_ptr_q];
  end

  // Acceptance, pointer wrap and next-state for counter and error flags.
  always_comb begin
    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    pop_ok      = pop & ~empty;
    push_ok     = push & (~full | pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (push & ~push_ok);
    underflow_d = underflow_q | (pop & empty);
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; the array carries no reset and a flush discards the push.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_ff_fifo_any_depth_flags.sv
// Directed self-checking bench for ff_fifo_any_depth_flags (width 8, depth 6).
module tb_ff_fifo_any_depth_flags;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  ff_fifo_any_depth_flags #(
    .width             (8),
    .depth             (6),
    .almost_full_level (4),
    .almost_empty_level(1)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push        (push),
    .pop         (pop),
    .write_data  (write_data),
    .read_data   (read_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls, then sample 1 ns after the edge.
  task automatic cycle(input logic c, input logic pu, input logic po, input logic [7:0] d);
    clear      = c;
    push       = pu;
    pop        = po;
    write_data = d;
    @(posedge clk);
    #1;
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic check_status(input string tag, input int n, input logic ovf, input logic udf);
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == 6));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
    check({tag, ".afull"}, 32'(almost_full), 32'(n >= 4));
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(udf));
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    write_data = 8'h00;
    #12;
    rst = 1'b0;
    #1;
    check_status("reset", 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check_status("idle", 0, 1'b0, 1'b0);

    // Fill with 0x10..0x15; head stays 0x10 throughout.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
      check_status($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
      check("fill.head", 32'(read_data), 32'h10);
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain%0d.data", i), 32'(read_data), 32'(8'h10 + i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d.count", i), 32'(count), 32'(5 - i));
    end
    check_status("drained", 0, 1'b0, 1'b0);

    // Advance both pointers to 4 so the next fill wraps wr_ptr 5 -> 0.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pre%0d.data", i), 32'(read_data), 32'(8'h30 + i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    check_status("wrap.full", 6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wrap%0d.data", i), 32'(read_data), 32'(8'hA0 + i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    check_status("wrap.empty", 0, 1'b0, 1'b0);

    // Push and pop together while full: 0x50 leaves, 0x77 lands at the tail.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    check_status("fullpp", 6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fullpp%0d.data", i), 32'(read_data), 32'(8'h51 + i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    check("fullpp.tail", 32'(read_data), 32'h77);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check_status("fullpp.empty", 0, 1'b0, 1'b0);

    // Rejected push while full sets a sticky overflow.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'hEE);
    check_status("ovf", 6, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ovf%0d.data", i), 32'(read_data), 32'(8'h60 + i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    check_status("ovf.sticky", 0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check_status("udf", 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check_status("clr.flags", 0, 1'b0, 1'b0);

    // Push+pop on empty: only the push is taken, underflow sets.
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    check_status("emptypp", 1, 1'b0, 1'b1);
    check("emptypp.data", 32'(read_data), 32'h5A);

    // Fill to 3, then flush with a simultaneous push that must be dropped.
    cycle(1'b0, 1'b1, 1'b0, 8'h5B);
    cycle(1'b0, 1'b1, 1'b0, 8'h5C);
    check_status("pre.clr", 3, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h99);
    check_status("clr.push", 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'hC3);
    check_status("post.clr", 1, 1'b0, 1'b0);
    check("post.clr.data", 32'(read_data), 32'hC3);

    // Asynchronous reset between clock edges.
    cycle(1'b0, 1'b1, 1'b0, 8'hC4);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check_status("pre.rst", 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'hD0);
    cycle(1'b0, 1'b1, 1'b0, 8'hD1);
    check("pre.rst.count", 32'(count), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check_status("async.rst", 0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 8'hE1);
    check_status("after.rst", 1, 1'b0, 1'b0);
    check("after.rst.data", 32'(read_data), 32'hE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
